// File: rtl/xor_puf_ctrl.sv
// Clocked controller for a K-chain XOR arbiter PUF: fans out rotated challenges,
// fires each race VOTES times and majority-votes the XOR of the arbiter outputs.
module xor_puf_ctrl #(
    parameter int unsigned N      = 128,
    parameter int unsigned K      = 4,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned VOTES  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     challenge,
    output logic             busy,
    output logic [K*N-1:0]   chal_out,
    output logic             launch,
    output logic             latch_rst,
    input  logic [K-1:0]     arb_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp,
    output logic             stable,
    output logic [K-1:0]     raw
);

    localparam int unsigned VW = $clog2(VOTES + 1);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [VW-1:0] LAST_VOTE   = VW'(VOTES - 1);
    localparam logic [VW-1:0] HALF_VOTES  = VW'(VOTES / 2);
    localparam logic [VW-1:0] ALL_VOTES   = VW'(VOTES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FIRE   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   settle_cnt;
    logic [VW-1:0]   vote_idx;
    logic [VW-1:0]   ones;
    logic [VW-1:0]   ones_next;
    logic            accept;
    logic            settle_done;
    logic            last_vote;
    logic            arb_xor;
    logic            busy_d;
    logic            launch_d;
    logic            latch_rst_d;
    logic            resp_valid_d;
    logic [K*N-1:0]  chal_rot;

    assign accept      = (state == S_IDLE) && start;
    assign settle_done = (settle_cnt == '0);
    assign last_vote   = (vote_idx == LAST_VOTE);
    assign arb_xor     = ^arb_in;
    assign ones_next   = ones + VW'(arb_xor);

    // Chain k gets the challenge rotated left by k bits.
    for (genvar k = 0; k < K; k++) begin : g_chain
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign chal_rot[k*N + i] = challenge[(i + N - (k % N)) % N];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_ARM;
            S_ARM:    state_next = S_FIRE;
            S_FIRE:   if (settle_done) state_next = S_SAMPLE;
            S_SAMPLE: state_next = last_vote ? S_DONE : S_ARM;
            S_DONE:   if (resp_valid && resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        busy_d       = 1'b0;
        launch_d     = 1'b0;
        latch_rst_d  = 1'b1;
        resp_valid_d = 1'b0;
        case (state_next)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_ARM: begin
                busy_d = 1'b1;
            end
            S_FIRE, S_SAMPLE: begin
                busy_d      = 1'b1;
                launch_d    = 1'b1;
                latch_rst_d = 1'b0;
            end
            S_DONE: begin
                busy_d       = 1'b1;
                resp_valid_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            launch     <= 1'b0;
            latch_rst  <= 1'b1;
            resp_valid <= 1'b0;
            resp       <= 1'b0;
            stable     <= 1'b0;
            raw        <= '0;
            chal_out   <= '0;
            settle_cnt <= '0;
            vote_idx   <= '0;
            ones       <= '0;
        end else begin
            busy       <= busy_d;
            launch     <= launch_d;
            latch_rst  <= latch_rst_d;
            resp_valid <= resp_valid_d;

            if (accept) begin
                chal_out <= chal_rot;
                ones     <= '0;
                vote_idx <= '0;
            end

            if (state == S_ARM) begin
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == S_FIRE) && !settle_done) begin
                settle_cnt <= settle_cnt - SW'(1);
            end

            // arb_in is only looked at here; glitches while racing are ignored.
            if (state == S_SAMPLE) begin
                raw      <= arb_in;
                ones     <= ones_next;
                vote_idx <= vote_idx + VW'(1);
                if (last_vote) begin
                    resp   <= (ones_next > HALF_VOTES);
                    stable <= (ones_next == '0) || (ones_next == ALL_VOTES);
                end
            end
        end
    end

endmodule
